// File: rtl/mealy_seq_detector_if.sv
// rtl/mealy_seq_detector_if.sv - serial-bit, pattern-load and status bundle for mealy_seq_detector
interface mealy_seq_detector_if #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
);
  localparam int ST_W = $clog2(PAT_W) + 1;

  logic             en;
  logic             a_in;
  logic             pat_load;
  logic [PAT_W-1:0] pat_in;
  logic [1:0]       b_out;
  logic [ST_W-1:0]  st;
  logic [CNT_W-1:0] match_cnt;

  modport master (
    output en, a_in, pat_load, pat_in,
    input  b_out, st, match_cnt
  );

  modport slave (
    input  en, a_in, pat_load, pat_in,
    output b_out, st, match_cnt
  );
endinterface

// File: rtl/mealy_seq_detector.sv
// rtl/mealy_seq_detector.sv - Mealy serial pattern detector with loadable pattern
// Optional saturating match counter enabled by macro MEALY_DET_CNT_EN.
module mealy_seq_detector #(
  parameter int PAT_W   = 4,
  parameter int CNT_W   = 8,
  parameter int OVERLAP = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  mealy_seq_detector_if.slave  io
);
  localparam int ST_W = $clog2(PAT_W) + 1;
  localparam logic [ST_W-1:0] ST_FULL = ST_W'(PAT_W - 1);

  function automatic logic [PAT_W-1:0] alt_pattern();
    logic [PAT_W-1:0] p;
    for (int i = 0; i < PAT_W; i++) begin
      p[i] = (((PAT_W - 1 - i) % 2) == 0);
    end
    return p;
  endfunction

  localparam logic [PAT_W-1:0] PAT_RST = alt_pattern();

  logic [PAT_W-1:0] pattern_q, pattern_d;
  logic [PAT_W-2:0] hist_q, hist_d;
  logic [ST_W-1:0]  st_q, st_d;
  logic             b1_q;
  logic             match;
  logic [PAT_W-1:0] shifted;

  assign shifted = {hist_q, io.a_in};

  always_ff @(posedge clk) begin
    if (reset) begin
      pattern_q <= PAT_RST;
      hist_q    <= '0;
      st_q      <= '0;
      b1_q      <= 1'b0;
    end else begin
      pattern_q <= pattern_d;
      hist_q    <= hist_d;
      st_q      <= st_d;
      b1_q      <= match;
    end
  end

  // pat_load wins over en; a_in is dropped on a load cycle
  always_comb begin
    pattern_d = pattern_q;
    hist_d    = hist_q;
    st_d      = st_q;
    if (io.pat_load) begin
      pattern_d = io.pat_in;
      st_d      = '0;
    end else if (io.en) begin
      hist_d = shifted[PAT_W-2:0];
      if (match) begin
        st_d = (OVERLAP != 0) ? ST_FULL : '0;
      end else if (st_q != ST_FULL) begin
        st_d = st_q + ST_W'(1);
      end
    end
  end

  always_comb begin
    match = 1'b0;
    if (!reset && io.en && !io.pat_load && (st_q == ST_FULL) && (shifted == pattern_q)) begin
      match = 1'b1;
    end
  end

  assign io.b_out = {b1_q, match};
  assign io.st    = st_q;

`ifdef MEALY_DET_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (io.pat_load) begin
      cnt_d = '0;
    end else if (match && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign io.match_cnt = cnt_q;
`else
  assign io.match_cnt = '0;
`endif
endmodule

// File: doc/mealy_seq_detector.md
MEALY_SEQ_DETECTOR -- requirements
Module: mealy_seq_detector

Interface
REQ-001 SHALL have parameter PAT_W, default 4, pattern length in bits, legal range 2..16.
REQ-002 SHALL have parameter CNT_W, default 8, match-counter width in bits.
REQ-003 SHALL have parameter OVERLAP, default 1: 1 = overlapping detection, 0 = non-overlapping.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port en, input, 1 bit: qualifies a_in as a valid serial bit this cycle.
REQ-007 SHALL have port a_in, input, 1 bit: serial data bit.
REQ-008 SHALL have port pat_load, input, 1 bit: strobe to capture pat_in.
REQ-009 SHALL have port pat_in, input, PAT_W bits: new pattern; MSB is the first bit received.
REQ-010 SHALL have port b_out, output, 2 bits: b_out[0] is the combinational Mealy match; b_out[1] is b_out[0] registered one cycle later.
REQ-011 SHALL have port st, output, $clog2(PAT_W)+1 bits: fill state, i.e. number of valid history bits.
REQ-012 SHALL have port match_cnt, output, CNT_W bits: saturating match count (see Configuration).

Function
REQ-013 SHALL keep a history register hist of PAT_W-1 bits and a fill counter st in range 0..PAT_W-1.
REQ-014 SHALL drive b_out[0] = en & ~pat_load & (st == PAT_W-1) & ({hist, a_in} == pattern), with zero clock latency from a_in (Mealy).
REQ-015 On each clk edge with en=1 and no match, SHALL shift a_in into the LSB of hist and set st to min(st+1, PAT_W-1).
REQ-016 On a match with OVERLAP=1, SHALL shift a_in into hist and hold st at PAT_W-1, so the next match may occur one bit later.
REQ-017 On a match with OVERLAP=0, SHALL clear st to 0, so the next match needs PAT_W fresh bits.
REQ-018 With en=0, SHALL hold hist and st, and b_out[0] SHALL be 0.
REQ-019 SHALL register b_out[1] <= b_out[0] on every edge, regardless of en.
REQ-020 When pat_load=1, SHALL capture pat_in into pattern, clear st to 0, and ignore a_in that cycle; pat_load SHALL take priority over en.
REQ-021 SHALL make reset take priority over pat_load and en.

Reset
REQ-022 Reset SHALL set pattern to PAT_W'b1010... (MSB first, alternating, starting with 1).
REQ-023 Reset SHALL set hist, st, b_out[1] and match_cnt to 0.
REQ-024 Reset SHALL force b_out[0] to 0 in the cycle reset is high.
REQ-025 A reset asserted mid-sequence SHALL discard all partial progress; detection SHALL restart from st=0.

Configuration
REQ-026 With macro MEALY_DET_CNT_EN defined, match_cnt SHALL increment on every b_out[0]=1 edge, saturate at 2^CNT_W-1, and clear on reset or pat_load.
REQ-027 Without MEALY_DET_CNT_EN, match_cnt SHALL be tied to 0 and no counter logic SHALL be synthesised.

Verification
REQ-028 Scenario: PAT_W=4, OVERLAP=1, reset pattern 1010, en=1, stream 1,0,1,0,1,0 -> b_out[0]=1 on bits 4 and 6; b_out[1]=1 one cycle after each.
REQ-029 Scenario: same stream, OVERLAP=0 -> b_out[0]=1 on bit 4 only; st returns to 0 after bit 4 and reaches 2 after bit 6.
REQ-030 Scenario: pat_load with pat_in=0011 after 2 bits, then stream 0,0,1,1 -> st=0 after the load; b_out[0]=1 on the 4th bit.
REQ-031 Scenario: stream 1,0,1, then en=0 for 3 cycles with a_in=0, then a_in=0 with en=1 -> no match while en=0; match on the final bit.
REQ-032 Scenario: reset pulse after 1,0,1, then 0 -> no match; st=1 after that bit.
REQ-033 Scenario: MEALY_DET_CNT_EN, CNT_W=2, 5 overlapping matches -> match_cnt sequence 1,2,3,3,3; without the macro, match_cnt stays 0.
